// File: rtl/torus_pkg.sv
// torus_pkg: shared types and helpers for torus control blocks.
package torus_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TMO} run_state_t;

  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_n.sv
// popcount_n: combinational N-bit population count as a recursive adder tree.
module popcount_n
  import torus_pkg::*;
#(
  parameter int N = 8,
  parameter int W = pc_width(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] cnt
);

  if (N == 1) begin : g_leaf
    assign cnt = W'(bits);
  end else begin : g_node
    localparam int L = N / 2;
    localparam int R = N - L;
    logic [pc_width(L)-1:0] lo;
    logic [pc_width(R)-1:0] hi;
    popcount_n #(.N(L)) u_lo (.bits(bits[L-1:0]), .cnt(lo));
    popcount_n #(.N(R)) u_hi (.bits(bits[N-1:L]), .cnt(hi));
    assign cnt = W'(lo) + W'(hi);
  end

endmodule

// File: rtl/torus_run_ctrl.sv
// torus_run_ctrl: run gating, done-stability window, watchdog and delivered-packet accounting.
module torus_run_ctrl
  import torus_pkg::*;
#(
  parameter int N_PE      = 16,
  parameter int N_PACKETS = 12,
  parameter int CYC_W     = 16,
  parameter int TIMEOUT   = 1024,
  parameter int DONE_HOLD = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_PE-1:0]  pe_done,
  input  logic [N_PE-1:0]  rx_v,
  output logic             run,
  output logic             finished,
  output logic             timed_out,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CNT_W-1:0] rx_total,
  output logic             count_ok
);

  localparam int PC_W   = pc_width(N_PE);
  localparam int HOLD_W = pc_width(DONE_HOLD);
  localparam int SUM_W  = (CNT_W > PC_W ? CNT_W : PC_W) + 1;
  localparam int unsigned EXP = N_PE * N_PACKETS;

  run_state_t        state, nstate;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PC_W-1:0]   rx_pc;
  logic [SUM_W-1:0]  rx_sum;
  logic [CNT_W-1:0]  rx_nxt;
  logic              all_done, done_hit, tmo_hit;

  popcount_n #(.N(N_PE)) u_pc (.bits(rx_v), .cnt(rx_pc));

  // Done beats the watchdog; start overrides everything, including an exit decision.
  always_comb begin
    all_done = &pe_done;
    done_hit = all_done && hold_cnt == HOLD_W'(DONE_HOLD - 1);
    tmo_hit  = cycle_count == CYC_W'(TIMEOUT - 1);
    rx_sum   = SUM_W'(rx_total) + SUM_W'(rx_pc);
    rx_nxt   = rx_sum > SUM_W'({CNT_W{1'b1}}) ? '1 : rx_sum[CNT_W-1:0];
    nstate   = start ? ST_RUN :
               state != ST_RUN ? state :
               done_hit ? ST_DONE :
               tmo_hit ? ST_TMO : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      rx_total    <= '0;
      run         <= 1'b0;
      finished    <= 1'b0;
      timed_out   <= 1'b0;
      count_ok    <= 1'b0;
    end else begin
      state     <= nstate;
      run       <= nstate == ST_RUN;
      finished  <= nstate == ST_DONE;
      timed_out <= nstate == ST_TMO;
      if (start) begin
        hold_cnt    <= '0;
        cycle_count <= '0;
        rx_total    <= '0;
        count_ok    <= 1'b0;
      end else if (state == ST_RUN) begin
        hold_cnt    <= all_done ? hold_cnt + 1'b1 : '0;
        cycle_count <= nstate == ST_RUN ? cycle_count + 1'b1 : cycle_count;
        rx_total    <= rx_nxt;
        count_ok    <= nstate == ST_DONE && 32'(rx_nxt) == EXP;
      end
    end
  end

endmodule

// File: tb/tb_torus_run_ctrl.sv
// tb_torus_run_ctrl: directed and randomized checks of torus_run_ctrl against a run-level reference model.
module tb_torus_run_ctrl;

  localparam int N = 16;
  localparam int TMO = 1024;
  localparam int HOLD = 2;
  localparam int TOTAL = 192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [N-1:0] pe_done = '0;
  logic [N-1:0] rx_v = '0;

  logic run, finished, timed_out, count_ok;
  logic [15:0] cycle_count, rx_total;
  logic s_run, s_finished, s_timed_out, s_count_ok;
  logic [15:0] s_cycle_count;
  logic [3:0] s_rx_total;

  int compared = 0;
  int mismatched = 0;

  bit m_running, m_fin, m_tmo;
  int m_cyc, m_rx, m_streak;

  always #5 clk = ~clk;

  torus_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pe_done(pe_done), .rx_v(rx_v),
    .run(run), .finished(finished), .timed_out(timed_out),
    .cycle_count(cycle_count), .rx_total(rx_total), .count_ok(count_ok)
  );

  torus_run_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pe_done(pe_done), .rx_v(rx_v),
    .run(s_run), .finished(s_finished), .timed_out(s_timed_out),
    .cycle_count(s_cycle_count), .rx_total(s_rx_total), .count_ok(s_count_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  // Run-level view: a run ends once the done streak reaches HOLD, else when the cycle budget is spent.
  task automatic model(input bit r, input bit st, input logic [N-1:0] pd, input logic [N-1:0] rv);
    if (r) begin
      m_running = 0; m_fin = 0; m_tmo = 0; m_cyc = 0; m_rx = 0; m_streak = 0;
    end else if (st) begin
      m_running = 1; m_fin = 0; m_tmo = 0; m_cyc = 0; m_rx = 0; m_streak = 0;
    end else if (m_running) begin
      m_rx += $countones(rv);
      m_streak = (pd == '1) ? m_streak + 1 : 0;
      if (m_streak >= HOLD) begin
        m_running = 0; m_fin = 1;
      end else if (m_cyc == TMO - 1) begin
        m_running = 0; m_tmo = 1;
      end else m_cyc++;
    end
  endtask

  task automatic check_all();
    chk("run", 64'(run), 64'(m_running));
    chk("finished", 64'(finished), 64'(m_fin));
    chk("timed_out", 64'(timed_out), 64'(m_tmo));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("rx_total", 64'(rx_total), 64'(sat(m_rx, 16)));
    chk("count_ok", 64'(count_ok), 64'(m_fin && sat(m_rx, 16) == TOTAL));
    chk("sat_rx_total", 64'(s_rx_total), 64'(sat(m_rx, 4)));
    chk("sat_count_ok", 64'(s_count_ok), 64'(0));
  endtask

  task automatic step(input bit r, input bit st, input logic [N-1:0] pd, input logic [N-1:0] rv);
    rst = r; start = st; pe_done = pd; rx_v = rv;
    @(posedge clk);
    model(r, st, pd, rv);
    #1 check_all();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] not_all();
    logic [N-1:0] m;
    m = N'($urandom);
    m[$urandom_range(0, N - 1)] = 1'b0;
    return m;
  endfunction

  function automatic logic [N-1:0] rand_mask(input int k);
    logic [N-1:0] m;
    m = '0;
    while ($countones(m) < k) m[$urandom_range(0, N - 1)] = 1'b1;
    return m;
  endfunction

  // Spreads exactly 'total' delivered packets over 'cycles' run cycles.
  task automatic deliver(input int total, input int cycles);
    int rem, k;
    rem = total;
    for (int left = cycles; left > 0; left--) begin
      k = (rem + left - 1) / left + $urandom_range(0, 2);
      if (k > rem) k = rem;
      if (k > N) k = N;
      step(0, 0, not_all(), rand_mask(k));
      rem -= k;
    end
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, '0, '0);
    step(1, 0, '1, '1);
    chk("reset_run", 64'(run), 64'(0));

    // Normal run: first RUN cycle is cycle 0, done at cycles 60 and 61.
    step(0, 1, '0, '0);
    chk("start_run", 64'(run), 64'(1));
    deliver(TOTAL, 50);
    for (int i = 50; i < 60; i++) step(0, 0, not_all(), '0);
    step(0, 0, '1, '0);
    chk("hold1_fin", 64'(finished), 64'(0));
    step(0, 0, '1, '0);
    chk("normal_fin", 64'(finished), 64'(1));
    chk("normal_cyc", 64'(cycle_count), 64'(61));
    chk("normal_rx", 64'(rx_total), 64'(TOTAL));
    chk("normal_ok", 64'(count_ok), 64'(1));
    step(0, 0, '1, '1);
    chk("done_frozen_rx", 64'(rx_total), 64'(TOTAL));

    // Short count from DONE: restart clears finished next cycle.
    step(0, 1, '0, '0);
    chk("restart_fin", 64'(finished), 64'(0));
    chk("restart_run", 64'(run), 64'(1));
    deliver(TOTAL - 1, 50);
    step(0, 0, '1, '0);
    step(0, 0, '1, '0);
    chk("short_fin", 64'(finished), 64'(1));
    chk("short_ok", 64'(count_ok), 64'(0));

    // Done glitch: high, low, high, high.
    step(0, 1, '0, '0);
    step(0, 0, '1, '0);
    step(0, 0, not_all(), '0);
    step(0, 0, '1, '0);
    chk("glitch_fin_early", 64'(finished), 64'(0));
    step(0, 0, '1, '0);
    chk("glitch_fin", 64'(finished), 64'(1));

    // Watchdog with random traffic; the 4-bit counter saturates.
    step(0, 1, '0, '0);
    for (int i = 0; i < TMO; i++) begin
      chk("wd_run", 64'(run), 64'(1));
      step(0, 0, not_all(), N'($urandom));
    end
    chk("wd_tmo", 64'(timed_out), 64'(1));
    chk("wd_run_low", 64'(run), 64'(0));
    chk("wd_cyc", 64'(cycle_count), 64'(TMO - 1));
    chk("wd_fin", 64'(finished), 64'(0));
    chk("wd_sat", 64'(s_rx_total), 64'(15));

    // Done window completes on cycle TIMEOUT-1.
    step(0, 1, '0, '0);
    for (int i = 0; i < TMO - 2; i++) step(0, 0, not_all(), '0);
    step(0, 0, '1, '0);
    step(0, 0, '1, '0);
    chk("simul_fin", 64'(finished), 64'(1));
    chk("simul_tmo", 64'(timed_out), 64'(0));

    // Reset mid-run, then a fresh run; also restart while running.
    step(0, 1, '0, '0);
    for (int i = 0; i < 30; i++) step(0, 0, not_all(), N'($urandom));
    step(1, 0, '1, '1);
    chk("rst_run", 64'(run), 64'(0));
    chk("rst_cyc", 64'(cycle_count), 64'(0));
    chk("rst_rx", 64'(rx_total), 64'(0));
    step(0, 1, '0, '1);
    chk("fresh_cyc", 64'(cycle_count), 64'(0));
    for (int i = 0; i < 5; i++) step(0, 0, not_all(), N'($urandom));
    step(0, 1, '1, '1);
    chk("rerun_cyc", 64'(cycle_count), 64'(0));
    chk("rerun_rx", 64'(rx_total), 64'(0));

    // Random soak.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0 ? '1 : not_all(), N'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
